adda_stream: RTL and testbench

Parametrised sample engine for the ULX3S J2 AD/DA add-on. It generates the ADC and DAC sample clocks from the 25 MHz system clock using a runtime divider. ADC samples are captured into a first-word-fall-through FIFO with overflow detection. The DAC is driven in one of four modes: loopback, ramp, constant or idle. It sits between the J2 pins and the consumer logic inside `top`, replacing direct pin wiring.

---
 rtl/adda_stream.sv | 200 ++++++++++++++++++++
 tb/tb_adda_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adda_stream.sv
// adda_stream: sample engine for the ULX3S J2 AD/DA add-on.
// Derives the ADC/DAC sample clocks from the system clock with a runtime
// divider, pushes ADC samples into a first-word-fall-through FIFO with a
// sticky overflow flag, and drives the DAC from loopback, ramp, constant
// or idle sources.
// Optional feature: define ADDA_DECIM_EN to average every 4 captures into
// a single FIFO entry (loopback still uses raw samples).
module adda_stream #(
  parameter int DATA_W  = 8,
  parameter int DIV_W   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [DIV_W-1:0]     i_div,
  input  logic [1:0]           i_mode,
  input  logic [DATA_W-1:0]    i_const,
  output logic                 o_J2_AD_CLK,
  input  logic [DATA_W-1:0]    i_J2_AD_PORT,
  output logic                 o_J2_DA_CLK,
  output logic [DATA_W-1:0]    o_J2_DA_PORT,
  output logic [DATA_W-1:0]    o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic [FIFO_AW:0]     o_level,
  output logic                 o_overflow,
  input  logic                 i_clr_ovf
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] MODE_LOOP  = 2'b00;
  localparam logic [1:0] MODE_RAMP  = 2'b01;
  localparam logic [1:0] MODE_CONST = 2'b10;

  localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Sample timing
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] d_eff;
  logic [DIV_W:0]   half;
  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic             clk_next;
  logic             ad_clk_reg;
  logic             da_clk_reg;
  logic             strobe;

  // A divider of 0 behaves as 1 so the period never collapses to a single cycle.
  assign d_eff    = (i_div == '0) ? DIV_W'(1) : i_div;
  assign half     = ({1'b0, d_eff} + (DIV_W+1)'(1)) >> 1;
  assign strobe   = i_enable && (cnt_reg == '0);

  // Phase counter next value; the >= compare also catches D shrinking mid-period.
  always_comb begin
    cnt_next = '0;
    if (i_enable && (cnt_reg < d_eff)) begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
  end

  // Clocks are computed from the next phase so the registered level matches cnt.
  assign clk_next = i_enable && ({1'b0, cnt_next} >= half);

  // Phase counter and the two registered J2 sample clocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg    <= '0;
      ad_clk_reg <= 1'b0;
      da_clk_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      ad_clk_reg <= clk_next;
      da_clk_reg <= clk_next;
    end
  end

  assign o_J2_AD_CLK = ad_clk_reg;
  assign o_J2_DA_CLK = da_clk_reg;

  // ---------------------------------------------------------------------
  // Capture path (raw or decimated)
  // ---------------------------------------------------------------------
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;

`ifdef ADDA_DECIM_EN
  logic [1:0]        cap_cnt_reg;
  logic [DATA_W+1:0] acc_reg;
  logic [DATA_W+1:0] sum;

  assign sum     = acc_reg + {2'b00, i_J2_AD_PORT};
  assign wr_req  = strobe && (cap_cnt_reg == 2'd3);
  assign wr_data = sum[DATA_W+1:2];

  // Accumulate four captures; the fourth emits the truncated mean and restarts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_cnt_reg <= '0;
      acc_reg     <= '0;
    end else if (!i_enable) begin
      cap_cnt_reg <= '0;
      acc_reg     <= '0;
    end else if (strobe) begin
      cap_cnt_reg <= cap_cnt_reg + 2'd1;
      acc_reg     <= (cap_cnt_reg == 2'd3) ? '0 : sum;
    end
  end
`else
  assign wr_req  = strobe;
  assign wr_data = i_J2_AD_PORT;
`endif

  // ---------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg;
  logic               ovf_reg;
  logic               full;
  logic               pop;
  logic               push;
  logic               ovf_set;

  // Level never exceeds DEPTH, so its top bit alone means full.
  assign full    = level_reg[FIFO_AW];
  assign pop     = o_rd_valid && i_rd_ready;
  assign push    = wr_req && (!full || pop);
  assign ovf_set = wr_req && full && !pop;

  // Sample storage; contents need no reset because level gates visibility.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag (set beats clear).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      end
      if (push && !pop) begin
        level_reg <= level_reg + (FIFO_AW+1)'(1);
      end else if (pop && !push) begin
        level_reg <= level_reg - (FIFO_AW+1)'(1);
      end
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign o_rd_valid = (level_reg != '0);
  assign o_rd_data  = mem[rd_ptr_reg];
  assign o_level    = level_reg;
  assign o_overflow = ovf_reg;

  // ---------------------------------------------------------------------
  // DAC source
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] ramp_reg;
  logic [DATA_W-1:0] da_reg;

  // DAC value and ramp only move on a strobe; mode/const are sampled there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ramp_reg <= '0;
      da_reg   <= MID_SCALE;
    end else if (strobe) begin
      case (i_mode)
        MODE_LOOP:  da_reg <= i_J2_AD_PORT;
        MODE_RAMP: begin
          da_reg   <= ramp_reg;
          ramp_reg <= ramp_reg + DATA_W'(1);
        end
        MODE_CONST: da_reg <= i_const;
        default:    da_reg <= MID_SCALE;
      endcase
    end
  end

  assign o_J2_DA_PORT = da_reg;

endmodule

// File: tb/tb_adda_stream.sv
// Directed self-checking bench for adda_stream (default build, no decimation).
module tb_adda_stream;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] div;
  logic [1:0] mode;
  logic [7:0] cnst;
  logic       ad_clk;
  logic [7:0] ad_port;
  logic       da_clk;
  logic [7:0] da_port;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] level;
  logic       overflow;
  logic       clr_ovf;

  int tests = 0;
  int fails = 0;
  logic [3:0] pat;

  adda_stream #(.DATA_W(8), .DIV_W(8), .FIFO_AW(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_div        (div),
    .i_mode       (mode),
    .i_const      (cnst),
    .o_J2_AD_CLK  (ad_clk),
    .i_J2_AD_PORT (ad_port),
    .o_J2_DA_CLK  (da_clk),
    .o_J2_DA_PORT (da_port),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .i_rd_ready   (rd_ready),
    .o_level      (level),
    .o_overflow   (overflow),
    .i_clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // One enabled cycle starting from cnt=0, then one idle cycle so cnt returns to 0.
  task automatic strobe_once();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; div = 8'd3; mode = 2'b11; cnst = 8'h00;
    ad_port = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0;
    pat = 4'b1100;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ad_clk", 32'(ad_clk), 0);
    chk("rst_da_clk", 32'(da_clk), 0);
    chk("rst_da_port", 32'(da_port), 'h80);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Clock pattern with D=3: 0,0,1,1
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ad_clk_pattern", 32'(ad_clk), 32'(pat[i % 4]));
      chk("da_clk_pattern", 32'(da_clk), 32'(pat[i % 4]));
      @(negedge clk);
    end
    chk("two_strobes_level", 32'(level), 2);

    // Asynchronous reset mid-operation
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_level", 32'(level), 0);
    chk("async_rst_valid", 32'(rd_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture four samples with D=1, then drain them in order
    div = 8'd1;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ad_port = 8'(8'hCC + k);
      @(negedge clk);
      @(negedge clk);
    end
    enable = 1'b0;
    chk("cap_level", 32'(level), 4);
    chk("cap_valid", 32'(rd_valid), 1);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("pop_data", 32'(rd_data), 32'('hCC + k));
      @(negedge clk);
    end
    chk("drain_valid", 32'(rd_valid), 0);
    chk("drain_level", 32'(level), 0);
    rd_ready = 1'b0;

    // Overflow: 16 strobes fill, 17th is dropped
    ad_port = 8'h11;
    enable = 1'b1;
    repeat (32) @(negedge clk);
    chk("full_level", 32'(level), 16);
    chk("full_no_ovf", 32'(overflow), 0);
    ad_port = 8'h99;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    chk("ovf_level", 32'(level), 16);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_head_kept", 32'(rd_data), 'h11);
    @(negedge clk);

    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Full write with simultaneous pop
    ad_port = 8'h22;
    rd_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    rd_ready = 1'b0;
    chk("full_pop_level", 32'(level), 16);
    chk("full_pop_no_ovf", 32'(overflow), 0);
    @(negedge clk);

    // Set and clear in the same cycle: set wins
    enable = 1'b1;
    clr_ovf = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    clr_ovf = 1'b0;
    chk("set_beats_clear", 32'(overflow), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp mode including wrap
    mode = 2'b01;
    strobe_once();
    chk("ramp_0", 32'(da_port), 0);
    strobe_once();
    chk("ramp_1", 32'(da_port), 1);
    strobe_once();
    chk("ramp_2", 32'(da_port), 2);
    repeat (253) strobe_once();
    chk("ramp_ff", 32'(da_port), 'hFF);
    strobe_once();
    chk("ramp_wrap", 32'(da_port), 0);

    // Constant mode applies only at the next strobe
    mode = 2'b10;
    cnst = 8'h5A;
    @(negedge clk);
    chk("const_held", 32'(da_port), 0);
    strobe_once();
    chk("const_5a", 32'(da_port), 'h5A);

    // Idle mode
    mode = 2'b11;
    strobe_once();
    chk("idle_80", 32'(da_port), 'h80);

    // Ramp held its value while in other modes
    mode = 2'b01;
    strobe_once();
    chk("ramp_held", 32'(da_port), 1);

    // Loopback visible in the cycle after the strobe edge
    mode = 2'b00;
    ad_port = 8'hD0;
    enable = 1'b1;
    @(negedge clk);
    chk("loopback_d0", 32'(da_port), 'hD0);
    enable = 1'b0;
    @(negedge clk);

    // Divider shrink mid-period, then disable
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    div = 8'd9;
    ad_port = 8'hD0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("div9_cnt5_clk", 32'(ad_clk), 1);
    chk("div9_da", 32'(da_port), 'hD0);
    div = 8'd2;
    ad_port = 8'h3C;
    @(negedge clk);
    chk("div_wrap_clk", 32'(ad_clk), 0);
    chk("div_wrap_da_hold", 32'(da_port), 'hD0);
    @(negedge clk);
    chk("div2_clk_high", 32'(ad_clk), 1);
    chk("div2_strobe_da", 32'(da_port), 'h3C);
    enable = 1'b0;
    ad_port = 8'h77;
    repeat (6) @(negedge clk);
    chk("dis_level", 32'(level), 2);
    chk("dis_ad_clk", 32'(ad_clk), 0);
    chk("dis_da_clk", 32'(da_clk), 0);
    chk("dis_da_held", 32'(da_port), 'h3C);
    chk("dis_head", 32'(rd_data), 'hD0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
